// File: rtl/multi_digit_display.sv
// N-digit multiplexed seven-segment driver: hex or decimal, leading-zero blanking, per-digit dp, 16-level PWM.
// Outputs are registered one cycle behind the scan counter; new values take 2 (hex) or 4*N+1 (decimal) busy cycles, never stall.
module multi_digit_display #(
    parameter int CLOCK_FREQ_HZ   = 100_000_000,
    parameter int REFRESH_RATE_HZ = 240,
    parameter int NUM_DIGITS      = 4,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    disp_en_i,
    input  logic                    hex_mode_i,
    input  logic                    blank_lz_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dots_i,
    input  logic [3:0]              brightness_i,
    output logic                    busy_o,
    output logic [NUM_DIGITS-1:0]   anodes_o,
    output logic [7:0]              cathodes_o
);
    localparam int VW   = 4 * NUM_DIGITS;
    localparam int SLOT = CLOCK_FREQ_HZ / (REFRESH_RATE_HZ * NUM_DIGITS);
    localparam int CW   = $clog2(SLOT);
    localparam int TW   = CW + 5;
    localparam int DW   = $clog2(NUM_DIGITS);
    localparam int SW   = $clog2(VW);
    localparam logic [VW-1:0]         MAX_DEC = VW'(10 ** NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]            CAT_OFF = {8{ACTIVE_LOW}};

    if (SLOT < 16) begin : g_slot_check
        $error("multi_digit_display: SLOT must be at least 16 cycles");
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   val_q, val_d, sh_q, sh_d, bcd_q, bcd_d, bcd_adj, dbuf_q, dbuf_d;
    logic            hex_q, hex_d, busy_d, dash_q, dash_d;
    logic [SW-1:0]   step_q, step_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            val_q   <= '0;
            hex_q   <= 1'b0;
            sh_q    <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            busy_o  <= 1'b0;
            dbuf_q  <= '0;
            dash_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            hex_q   <= hex_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            busy_o  <= busy_d;
            dbuf_q  <= dbuf_d;
            dash_q  <= dash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        hex_d   = hex_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        busy_d  = busy_o;
        dbuf_d  = dbuf_q;
        dash_d  = dash_q;
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (value_i != val_q || hex_mode_i != hex_q) begin
                    val_d   = value_i;
                    hex_d   = hex_mode_i;
                    sh_d    = value_i;
                    bcd_d   = '0;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (hex_q) begin
                    bcd_d   = val_q;
                    state_d = DONE;
                end else begin
                    {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
                    step_d = step_q + 1'b1;
                    if (step_q == SW'(VW - 1)) state_d = DONE;
                end
            end
            DONE: begin
                // Out-of-range decimal values leave garbage in bcd_q; the dash flag masks it.
                dbuf_d  = bcd_q;
                dash_d  = !hex_q && (val_q > MAX_DEC);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [CW-1:0]         cnt_q;
    logic [DW-1:0]         dig_q;
    logic [TW-1:0]         th;
    logic [NUM_DIGITS-1:0] upper_zero, an_act;
    logic [3:0]            nib;
    logic [6:0]            seg;
    logic                  lit, zero_run;

    assign th = ((TW'(brightness_i) + TW'(1)) * TW'(SLOT)) >> 4;

    // upper_zero[i]: digits i..N-1 of the buffer are all zero.
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (dbuf_q[4*i +: 4] == 4'd0);
            upper_zero[i] = zero_run;
        end
    end

    always_comb begin
        nib = dbuf_q[{dig_q, 2'b00} +: 4];
        if (dash_q)
            seg = 7'h40;
        else if (blank_lz_i && dig_q != '0 && upper_zero[dig_q])
            seg = 7'h00;
        else
            seg = seg7(nib);
        lit    = disp_en_i && ({{(TW-CW){1'b0}}, cnt_q} < th);
        an_act = lit ? (NUM_DIGITS'(1) << dig_q) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            dig_q      <= '0;
            anodes_o   <= AN_OFF;
            cathodes_o <= CAT_OFF;
        end else begin
            anodes_o   <= an_act ^ AN_OFF;
            cathodes_o <= (lit ? {dots_i[dig_q], seg} : 8'h00) ^ CAT_OFF;
            if (!disp_en_i) begin
                cnt_q <= '0;
                dig_q <= '0;
            end else if (cnt_q == CW'(SLOT - 1)) begin
                cnt_q <= '0;
                dig_q <= (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multi_digit_display.sv
// Bench for multi_digit_display: behavioural display/latency model checked every cycle, plus literal pins.
module tb_multi_digit_display;
    localparam int CLK_HZ = 6400;
    localparam int REF_HZ = 100;
    localparam int ND     = 4;
    localparam int SLOT   = CLK_HZ / (REF_HZ * ND);
    localparam logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        disp_en, hex_mode, blank_lz;
    logic [15:0] value;
    logic [3:0]  dots, brightness;
    logic        busy;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;

    multi_digit_display #(
        .CLOCK_FREQ_HZ(CLK_HZ), .REFRESH_RATE_HZ(REF_HZ), .NUM_DIGITS(ND), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .disp_en_i(disp_en), .hex_mode_i(hex_mode),
        .blank_lz_i(blank_lz), .value_i(value), .dots_i(dots), .brightness_i(brightness),
        .busy_o(busy), .anodes_o(anodes), .cathodes_o(cathodes)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;
    bit watch_blank = 1'b0;
    int blank_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected cathode byte for digit d of a displayed value.
    function automatic logic [7:0] digit_code(input int d, input int v, input bit h, input bit blz, input bit dot);
        int base, p;
        logic [7:0] c;
        base = h ? 16 : 10;
        p    = base ** d;
        if (!h && v > 9999)           c = 8'hBF;
        else if (blz && d > 0 && v < p) c = 8'hFF;
        else                          c = SEG_TAB[(v / p) % base];
        if (dot) c[7] = 1'b0;
        return c;
    endfunction

    int         m_lat_v = 0, m_show_v = 0, m_left = 0, m_t = 0;
    bit         m_lat_h = 0, m_show_h = 0;
    logic [3:0] exp_an = 4'hF;
    logic [7:0] exp_cat = 8'hFF;
    logic       exp_busy = 1'b0;

    always @(posedge clk or negedge rst_ni) begin : model
        int d, ph, th;
        if (!rst_ni) begin
            m_lat_v = 0; m_lat_h = 0; m_left = 0; m_show_v = 0; m_show_h = 0; m_t = 0;
            exp_an = 4'hF; exp_cat = 8'hFF; exp_busy = 1'b0;
        end else begin
            d  = m_t / SLOT;
            ph = m_t % SLOT;
            th = ((int'(brightness) + 1) * SLOT) >> 4;
            if (disp_en && ph < th) begin
                exp_an  = ~(4'b0001 << d);
                exp_cat = digit_code(d, m_show_v, m_show_h, blank_lz, dots[d]);
            end else begin
                exp_an  = 4'hF;
                exp_cat = 8'hFF;
            end
            m_t = disp_en ? (m_t + 1) % (SLOT * ND) : 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_show_v = m_lat_v;
                    m_show_h = m_lat_h;
                end
            end else if (int'(value) != m_lat_v || hex_mode != m_lat_h) begin
                m_lat_v = int'(value);
                m_lat_h = hex_mode;
                m_left  = hex_mode ? 2 : 4 * ND + 1;
            end
            exp_busy = (m_left != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("anodes", anodes, exp_an);
            check("cathodes", cathodes, exp_cat);
            check("busy", busy, exp_busy);
            if (watch_blank && anodes == 4'hF) blank_cycles++;
        end
    end

    int         fr_hits [4];
    logic [7:0] fr_cat  [4];

    task automatic capture_frame();
        for (int i = 0; i < 4; i++) begin fr_hits[i] = 0; fr_cat[i] = 8'h00; end
        for (int c = 0; c < SLOT * ND; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (anodes == ~(4'b0001 << d)) begin fr_hits[d]++; fr_cat[d] = cathodes; end
            end
        end
    endtask

    // Counts negedges with busy high; waits (bounded) for busy to rise first.
    task automatic measure_busy(output int len);
        int guard;
        len = 0; guard = 0;
        while (!busy && guard < 40) begin @(negedge clk); guard++; end
        if (!busy) begin
            check("busy_rise_timeout", 0, 1);
        end else begin
            while (busy && len < 100) begin @(negedge clk); len++; end
        end
    endtask

    initial begin
        int len, g;
        disp_en = 1'b1; hex_mode = 1'b0; blank_lz = 1'b0;
        value = 16'd0; dots = 4'd0; brightness = 4'd15;
        #3 rst_ni = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_anodes", anodes, 4'hF);
        check("rst_cathodes", cathodes, 8'hFF);
        check("rst_busy", busy, 1'b0);

        value = 16'd1234;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        measure_busy(len);
        check("dec_busy_len", len, 17);
        capture_frame();
        for (int d = 0; d < 4; d++) check("dec_hits", fr_hits[d], 16);
        check("dec_d0", fr_cat[0], 8'h99);
        check("dec_d1", fr_cat[1], 8'hB0);
        check("dec_d2", fr_cat[2], 8'hA4);
        check("dec_d3", fr_cat[3], 8'hF9);

        brightness = 4'd3;
        capture_frame();
        check("pwm3_d0", fr_hits[0], 4);
        check("pwm3_d3", fr_hits[3], 4);
        brightness = 4'd0;
        capture_frame();
        check("pwm0_d0", fr_hits[0], 1);
        check("pwm0_d2", fr_hits[2], 1);
        brightness = 4'd15;

        value = 16'd7; blank_lz = 1'b1;
        measure_busy(len);
        capture_frame();
        check("lz_d0", fr_cat[0], 8'hF8);
        check("lz_d1", fr_cat[1], 8'hFF);
        check("lz_d3", fr_cat[3], 8'hFF);
        dots = 4'b0101;
        capture_frame();
        check("dot_d0", fr_cat[0], 8'h78);
        check("dot_blank_d2", fr_cat[2], 8'h7F);
        dots = 4'd0;
        value = 16'd0;
        measure_busy(len);
        capture_frame();
        check("zero_d0", fr_cat[0], 8'hC0);
        check("zero_d1", fr_cat[1], 8'hFF);

        blank_lz = 1'b0; value = 16'd12000;
        measure_busy(len);
        capture_frame();
        check("ovf_d0", fr_cat[0], 8'hBF);
        check("ovf_d3", fr_cat[3], 8'hBF);
        hex_mode = 1'b1;
        measure_busy(len);
        check("hex_busy_len", len, 2);
        capture_frame();
        check("hex_d0", fr_cat[0], 8'hC0);
        check("hex_d1", fr_cat[1], 8'h86);
        check("hex_d2", fr_cat[2], 8'h86);
        check("hex_d3", fr_cat[3], 8'hA4);

        hex_mode = 1'b0; value = 16'd1234;
        blank_cycles = 0; watch_blank = 1'b1;
        repeat (6) @(negedge clk);
        value = 16'd5678;
        g = 0;
        while (busy && g < 40) begin @(negedge clk); g++; end
        g = 0;
        while (!busy && g < 10) begin @(negedge clk); g++; end
        check("rebusy_gap", g, 1);
        measure_busy(len);
        check("second_busy_len", len, 17);
        capture_frame();
        watch_blank = 1'b0;
        check("no_blank", blank_cycles, 0);
        check("upd_d0", fr_cat[0], 8'h80);
        check("upd_d1", fr_cat[1], 8'hF8);
        check("upd_d2", fr_cat[2], 8'h82);
        check("upd_d3", fr_cat[3], 8'h92);

        disp_en = 1'b0;
        @(negedge clk);
        check("en_off_anodes", anodes, 4'hF);
        check("en_off_cathodes", cathodes, 8'hFF);
        disp_en = 1'b1;
        @(negedge clk);
        check("en_on_anodes", anodes, 4'b1110);
        check("en_on_cathodes", cathodes, 8'h80);

        value = 16'd4321;
        repeat (5) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_anodes", anodes, 4'hF);
        check("mid_rst_cathodes", cathodes, 8'hFF);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("post_rst_anodes", anodes, 4'b1110);
        check("post_rst_cathodes", cathodes, 8'hC0);
        check("post_rst_busy", busy, 1'b1);
        measure_busy(len);
        check("post_rst_busy_len", len, 17);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       value = 16'($urandom_range(0, 65535));
                1:       value = 16'($urandom_range(0, 99));
                2:       value = 16'($urandom_range(9990, 10010));
                default: value = 16'($urandom_range(0, 9999));
            endcase
            hex_mode   = ($urandom_range(0, 3) == 0);
            blank_lz   = 1'($urandom_range(0, 1));
            dots       = 4'($urandom);
            brightness = 4'($urandom);
            disp_en    = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(1, 90)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
